// File: rtl/usb_dev_protocol_fsm_if.sv
// Packet, transmit and endpoint-data bundle for the device-side USB protocol engine.
// The slave modport is the engine's view; the master modport is the surrounding logic.
interface usb_dev_protocol_fsm_if;
  logic        pkt_valid;
  logic [3:0]  pkt_pid;
  logic [6:0]  pkt_addr;
  logic [3:0]  pkt_endp;
  logic [63:0] pkt_data;
  logic        pkt_corrupted;
  logic        tx_ready;
  logic        tx_valid;
  logic [3:0]  tx_pid;
  logic [63:0] tx_data;
  logic        in_data_valid;
  logic [63:0] in_data;
  logic        in_data_taken;
  logic        out_data_valid;
  logic [63:0] out_data;
  logic [3:0]  out_endp;
  logic        busy;
  logic        abort;

  modport slave (
    input  pkt_valid, pkt_pid, pkt_addr, pkt_endp, pkt_data, pkt_corrupted,
    input  tx_ready, in_data_valid, in_data,
    output tx_valid, tx_pid, tx_data, in_data_taken,
    output out_data_valid, out_data, out_endp, busy, abort
  );

  modport master (
    output pkt_valid, pkt_pid, pkt_addr, pkt_endp, pkt_data, pkt_corrupted,
    output tx_ready, in_data_valid, in_data,
    input  tx_valid, tx_pid, tx_data, in_data_taken,
    input  out_data_valid, out_data, out_endp, busy, abort
  );
endinterface

// File: rtl/usb_dev_protocol_fsm.sv
// Device-side USB protocol engine: answers OUT/IN tokens, ACKs/NAKs OUT data,
// sources IN data with retry/timeout, and reports payloads to the endpoint logic.
// Optional: define USB_DEV_STALL_EN to add stall_endp[15:0]; tokens to a stalled
// endpoint are then answered with STALL and no data is exchanged.
module usb_dev_protocol_fsm #(
  parameter int unsigned TIMEOUT_CYCLES = 20,
  parameter int unsigned MAX_RETRIES    = 8
) (
  input  logic                 clk,
  input  logic                 rst_L,
  input  logic [6:0]           my_addr,
`ifdef USB_DEV_STALL_EN
  input  logic [15:0]          stall_endp,
`endif
  usb_dev_protocol_fsm_if.slave bus
);

  localparam logic [3:0]  PID_OUT   = 4'b0001;
  localparam logic [3:0]  PID_IN    = 4'b1001;
  localparam logic [3:0]  PID_DATA0 = 4'b0011;
  localparam logic [3:0]  PID_ACK   = 4'b0010;
  localparam logic [3:0]  PID_NAK   = 4'b1010;
  localparam logic [3:0]  PID_STALL = 4'b1110;
  localparam logic [19:0] TMO       = 20'(TIMEOUT_CYCLES);
  localparam logic [3:0]  RMAX      = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {IDLE, W_DATA, S_DATA, W_ACK, S_HS} state_t;

  state_t      state;
  state_t      ret_state;
  logic [19:0] timer;
  logic [3:0]  retry;
  logic [63:0] payload;

  logic addr_hit;
  logic clean_hit;
  logic is_out_tok;
  logic is_in_tok;
  logic stall_hit;
  logic retry_ok;
  logic timed_out;

  function automatic logic [19:0] sat_inc_timer(input logic [19:0] v);
    return (v == 20'hFFFFF) ? v : v + 20'd1;
  endfunction

  function automatic logic [3:0] sat_inc_retry(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // Packet qualification: address filter first, corruption excludes tokens/handshakes
  assign addr_hit   = bus.pkt_valid && (bus.pkt_addr == my_addr);
  assign clean_hit  = addr_hit && !bus.pkt_corrupted;
  assign is_out_tok = clean_hit && (bus.pkt_pid == PID_OUT);
  assign is_in_tok  = clean_hit && (bus.pkt_pid == PID_IN);
  assign retry_ok   = (retry < RMAX);
  assign timed_out  = (timer == TMO);

`ifdef USB_DEV_STALL_EN
  assign stall_hit = stall_endp[bus.pkt_endp];
`else
  assign stall_hit = 1'b0;
`endif

  // Protocol FSM with all outputs registered; pulses default low every cycle
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state              <= IDLE;
      ret_state          <= IDLE;
      timer              <= '0;
      retry              <= '0;
      payload            <= '0;
      bus.tx_valid       <= 1'b0;
      bus.tx_pid         <= '0;
      bus.tx_data        <= '0;
      bus.in_data_taken  <= 1'b0;
      bus.out_data_valid <= 1'b0;
      bus.out_data       <= '0;
      bus.out_endp       <= '0;
      bus.busy           <= 1'b0;
      bus.abort          <= 1'b0;
    end else begin
      bus.in_data_taken  <= 1'b0;
      bus.out_data_valid <= 1'b0;
      bus.abort          <= 1'b0;
      case (state)
        IDLE: begin
          if (is_out_tok || is_in_tok) begin
            bus.busy <= 1'b1;
            if (stall_hit) begin
              bus.tx_valid <= 1'b1;
              bus.tx_pid   <= PID_STALL;
              bus.tx_data  <= '0;
              ret_state    <= IDLE;
              state        <= S_HS;
            end else if (is_out_tok) begin
              bus.out_endp <= bus.pkt_endp;
              timer        <= '0;
              retry        <= '0;
              state        <= W_DATA;
            end else if (bus.in_data_valid) begin
              bus.out_endp <= bus.pkt_endp;
              payload      <= bus.in_data;
              timer        <= '0;
              retry        <= '0;
              bus.tx_valid <= 1'b1;
              bus.tx_pid   <= PID_DATA0;
              bus.tx_data  <= bus.in_data;
              state        <= S_DATA;
            end else begin
              bus.tx_valid <= 1'b1;
              bus.tx_pid   <= PID_NAK;
              bus.tx_data  <= '0;
              ret_state    <= IDLE;
              state        <= S_HS;
            end
          end
        end
        W_DATA: begin
          if (addr_hit && (bus.pkt_pid == PID_DATA0)) begin
            if (!bus.pkt_corrupted) begin
              bus.out_data       <= bus.pkt_data;
              bus.out_data_valid <= 1'b1;
              bus.tx_valid       <= 1'b1;
              bus.tx_pid         <= PID_ACK;
              bus.tx_data        <= '0;
              ret_state          <= IDLE;
              state              <= S_HS;
            end else if (retry_ok) begin
              retry        <= sat_inc_retry(retry);
              timer        <= '0;
              bus.tx_valid <= 1'b1;
              bus.tx_pid   <= PID_NAK;
              bus.tx_data  <= '0;
              ret_state    <= W_DATA;
              state        <= S_HS;
            end else begin
              bus.abort <= 1'b1;
              bus.busy  <= 1'b0;
              state     <= IDLE;
            end
          end else if (!bus.pkt_valid) begin
            if (!timed_out) begin
              timer <= sat_inc_timer(timer);
            end else if (retry_ok) begin
              retry <= sat_inc_retry(retry);
              timer <= '0;
            end else begin
              bus.abort <= 1'b1;
              bus.busy  <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        S_DATA: begin
          if (bus.tx_ready) begin
            bus.tx_valid <= 1'b0;
            bus.tx_pid   <= '0;
            bus.tx_data  <= '0;
            timer        <= '0;
            state        <= W_ACK;
          end
        end
        W_ACK: begin
          if (clean_hit && (bus.pkt_pid == PID_ACK)) begin
            bus.in_data_taken <= 1'b1;
            bus.busy          <= 1'b0;
            state             <= IDLE;
          end else if ((addr_hit && (bus.pkt_corrupted || bus.pkt_pid == PID_NAK)) ||
                       (!bus.pkt_valid && timed_out)) begin
            if (retry_ok) begin
              retry        <= sat_inc_retry(retry);
              bus.tx_valid <= 1'b1;
              bus.tx_pid   <= PID_DATA0;
              bus.tx_data  <= payload;
              state        <= S_DATA;
            end else begin
              bus.abort <= 1'b1;
              bus.busy  <= 1'b0;
              state     <= IDLE;
            end
          end else if (!bus.pkt_valid) begin
            timer <= sat_inc_timer(timer);
          end
        end
        S_HS: begin
          if (bus.tx_ready) begin
            bus.tx_valid <= 1'b0;
            bus.tx_pid   <= '0;
            bus.tx_data  <= '0;
            bus.busy     <= (ret_state != IDLE);
            state        <= ret_state;
          end
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_dev_protocol_fsm.sv
// Testbench for usb_dev_protocol_fsm: cycle-by-cycle vector table plus
// hand-written sequences for timeout abort, NAK-limit abort and mid-transaction reset.
module tb_usb_dev_protocol_fsm;
  localparam int TMO  = 20;
  localparam int MAXR = 8;

  localparam logic [3:0] OUT = 4'b0001;
  localparam logic [3:0] IN  = 4'b1001;
  localparam logic [3:0] D0  = 4'b0011;
  localparam logic [3:0] ACK = 4'b0010;
  localparam logic [3:0] NAK = 4'b1010;

  localparam logic [63:0] DA1 = 64'hDEADBEEF_0123_4567;
  localparam logic [63:0] DA2 = 64'hA5A5_5A5A_0F0F_F0F0;
  localparam logic [63:0] ID1 = 64'h1122_3344_5566_7788;
  localparam logic [63:0] ID2 = 64'hCAFE_F00D_1234_5678;
  localparam logic [63:0] ID3 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] ID5 = 64'h5555_AAAA_3333_CCCC;
  localparam logic [63:0] BAD = 64'h0000_0000_0000_0BAD;

  logic       clk = 1'b0;
  logic       rst_L;
  logic [6:0] my_addr;
  int total = 0;
  int bad   = 0;

  usb_dev_protocol_fsm_if bus();
`ifdef USB_DEV_STALL_EN
  logic [15:0] stall_endp = 16'h0000;
`endif

  usb_dev_protocol_fsm #(.TIMEOUT_CYCLES(TMO), .MAX_RETRIES(MAXR)) dut (
    .clk       (clk),
    .rst_L     (rst_L),
    .my_addr   (my_addr),
`ifdef USB_DEV_STALL_EN
    .stall_endp(stall_endp),
`endif
    .bus       (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic pv; logic [3:0] pid; logic [6:0] addr; logic [3:0] endp; logic [63:0] data;
    logic corr; logic rdy; logic idv; logic [63:0] idat;
    logic e_txv; logic [3:0] e_pid; logic [63:0] e_txd; logic e_odv; logic [63:0] e_od;
    logic e_idt; logic e_ab; logic e_busy; logic [3:0] e_endp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t row(input logic pv, input logic [3:0] pid, input logic [6:0] addr,
                               input logic [3:0] endp, input logic [63:0] data, input logic corr,
                               input logic rdy, input logic idv, input logic [63:0] idat,
                               input logic txv, input logic [3:0] tpid, input logic [63:0] txd,
                               input logic odv, input logic [63:0] od, input logic idt,
                               input logic ab, input logic busy, input logic [3:0] oendp);
    vec_t v;
    v.pv = pv; v.pid = pid; v.addr = addr; v.endp = endp; v.data = data; v.corr = corr;
    v.rdy = rdy; v.idv = idv; v.idat = idat;
    v.e_txv = txv; v.e_pid = tpid; v.e_txd = txd; v.e_odv = odv; v.e_od = od;
    v.e_idt = idt; v.e_ab = ab; v.e_busy = busy; v.e_endp = oendp;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic pv, input logic [3:0] pid, input logic [6:0] addr,
                       input logic [3:0] endp, input logic [63:0] data, input logic corr,
                       input logic rdy, input logic idv, input logic [63:0] idat);
    bus.pkt_valid = pv; bus.pkt_pid = pid; bus.pkt_addr = addr; bus.pkt_endp = endp;
    bus.pkt_data = data; bus.pkt_corrupted = corr; bus.tx_ready = rdy;
    bus.in_data_valid = idv; bus.in_data = idat;
  endtask

  task automatic quiet();
    drive(1'b0, 4'h0, 7'd5, 4'h0, 64'h0, 1'b0, 1'b1, 1'b0, 64'h0);
  endtask

  initial begin
    int xfers, first_x, second_x, naks;
    logic idt_seen, ab_seen;
    logic [63:0] last_xd;

    // Table: pv pid addr endp data corr rdy idv idat | txv pid txd odv od idt ab busy endp
    vecs.push_back(row(0, 0,   5, 0, 0,   0, 1, 0, 0,   0, 0,   0,   0, 0,   0, 0, 0, 0));
    vecs.push_back(row(1, OUT, 5, 2, 0,   0, 1, 0, 0,   0, 0,   0,   0, 0,   0, 0, 1, 2));
    vecs.push_back(row(1, D0,  5, 0, DA1, 0, 1, 0, 0,   1, ACK, 0,   1, DA1, 0, 0, 1, 2));
    vecs.push_back(row(0, 0,   5, 0, 0,   0, 1, 0, 0,   0, 0,   0,   0, 0,   0, 0, 0, 2));
    vecs.push_back(row(1, OUT, 5, 3, 0,   0, 1, 0, 0,   0, 0,   0,   0, 0,   0, 0, 1, 3));
    vecs.push_back(row(1, D0,  5, 0, BAD, 1, 1, 0, 0,   1, NAK, 0,   0, 0,   0, 0, 1, 3));
    vecs.push_back(row(0, 0,   5, 0, 0,   0, 1, 0, 0,   0, 0,   0,   0, 0,   0, 0, 1, 3));
    vecs.push_back(row(1, D0,  5, 0, BAD, 1, 1, 0, 0,   1, NAK, 0,   0, 0,   0, 0, 1, 3));
    vecs.push_back(row(0, 0,   5, 0, 0,   0, 1, 0, 0,   0, 0,   0,   0, 0,   0, 0, 1, 3));
    vecs.push_back(row(1, D0,  5, 0, DA2, 0, 1, 0, 0,   1, ACK, 0,   1, DA2, 0, 0, 1, 3));
    vecs.push_back(row(0, 0,   5, 0, 0,   0, 1, 0, 0,   0, 0,   0,   0, 0,   0, 0, 0, 3));
    vecs.push_back(row(1, IN,  5, 1, 0,   0, 0, 1, ID1, 1, D0,  ID1, 0, 0,   0, 0, 1, 1));
    vecs.push_back(row(0, 0,   5, 0, 0,   0, 0, 0, 0,   1, D0,  ID1, 0, 0,   0, 0, 1, 1));
    vecs.push_back(row(1, ACK, 5, 0, 0,   0, 0, 0, 0,   1, D0,  ID1, 0, 0,   0, 0, 1, 1));
    vecs.push_back(row(0, 0,   5, 0, 0,   0, 0, 0, 0,   1, D0,  ID1, 0, 0,   0, 0, 1, 1));
    vecs.push_back(row(0, 0,   5, 0, 0,   0, 1, 0, 0,   0, 0,   0,   0, 0,   0, 0, 1, 1));
    vecs.push_back(row(1, ACK, 5, 0, 0,   0, 1, 0, 0,   0, 0,   0,   0, 0,   1, 0, 0, 1));
    vecs.push_back(row(0, 0,   5, 0, 0,   0, 1, 0, 0,   0, 0,   0,   0, 0,   0, 0, 0, 1));
    vecs.push_back(row(1, IN,  5, 4, 0,   0, 1, 0, 0,   1, NAK, 0,   0, 0,   0, 0, 1, 1));
    vecs.push_back(row(0, 0,   5, 0, 0,   0, 1, 0, 0,   0, 0,   0,   0, 0,   0, 0, 0, 1));
    vecs.push_back(row(1, OUT, 6, 2, 0,   0, 1, 0, 0,   0, 0,   0,   0, 0,   0, 0, 0, 1));
    vecs.push_back(row(1, IN,  6, 2, 0,   0, 1, 1, ID1, 0, 0,   0,   0, 0,   0, 0, 0, 1));
    vecs.push_back(row(1, OUT, 5, 7, 0,   1, 1, 0, 0,   0, 0,   0,   0, 0,   0, 0, 0, 1));
    vecs.push_back(row(0, 0,   5, 0, 0,   0, 1, 0, 0,   0, 0,   0,   0, 0,   0, 0, 0, 1));
    vecs.push_back(row(1, IN,  5, 5, 0,   0, 1, 1, ID2, 1, D0,  ID2, 0, 0,   0, 0, 1, 5));
    vecs.push_back(row(0, 0,   5, 0, 0,   0, 1, 0, 0,   0, 0,   0,   0, 0,   0, 0, 1, 5));
    vecs.push_back(row(1, NAK, 5, 0, 0,   0, 1, 0, 0,   1, D0,  ID2, 0, 0,   0, 0, 1, 5));
    vecs.push_back(row(0, 0,   5, 0, 0,   0, 1, 0, 0,   0, 0,   0,   0, 0,   0, 0, 1, 5));
    vecs.push_back(row(1, ACK, 5, 0, 0,   0, 1, 0, 0,   0, 0,   0,   0, 0,   1, 0, 0, 5));
    vecs.push_back(row(0, 0,   5, 0, 0,   0, 1, 0, 0,   0, 0,   0,   0, 0,   0, 0, 0, 5));

    // Reset state
    my_addr = 7'd5;
    rst_L   = 1'b0;
    quiet();
    tick(); tick();
    chk("rst tx_valid", bus.tx_valid, 0);
    chk("rst tx_pid", bus.tx_pid, 0);
    chk("rst tx_data", bus.tx_data, 0);
    chk("rst busy", bus.busy, 0);
    chk("rst out_endp", bus.out_endp, 0);
    chk("rst out_data", bus.out_data, 0);
    chk("rst pulses", {bus.out_data_valid, bus.in_data_taken, bus.abort}, 0);
    rst_L = 1'b1;
    tick();

    // Vector table
    foreach (vecs[i]) begin
      drive(vecs[i].pv, vecs[i].pid, vecs[i].addr, vecs[i].endp, vecs[i].data,
            vecs[i].corr, vecs[i].rdy, vecs[i].idv, vecs[i].idat);
      tick();
      chk($sformatf("r%0d tx_valid", i), bus.tx_valid, vecs[i].e_txv);
      chk($sformatf("r%0d tx_pid", i), bus.tx_pid, vecs[i].e_pid);
      chk($sformatf("r%0d tx_data", i), bus.tx_data, vecs[i].e_txd);
      chk($sformatf("r%0d out_data_valid", i), bus.out_data_valid, vecs[i].e_odv);
      if (vecs[i].e_odv) chk($sformatf("r%0d out_data", i), bus.out_data, vecs[i].e_od);
      chk($sformatf("r%0d in_data_taken", i), bus.in_data_taken, vecs[i].e_idt);
      chk($sformatf("r%0d abort", i), bus.abort, vecs[i].e_ab);
      chk($sformatf("r%0d busy", i), bus.busy, vecs[i].e_busy);
      chk($sformatf("r%0d out_endp", i), bus.out_endp, vecs[i].e_endp);
    end
    quiet();
    tick();

    // IN token, host silent: DATA0 resent on each timeout, abort after MAXR retries
    drive(1'b1, IN, 7'd5, 4'd6, 64'h0, 1'b0, 1'b1, 1'b1, ID3);
    tick();
    quiet();
    xfers = 0; first_x = -1; second_x = -1; idt_seen = 1'b0; ab_seen = 1'b0; last_xd = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (bus.tx_valid && bus.tx_pid == D0) begin
        if (xfers == 0) first_x = cyc;
        if (xfers == 1) second_x = cyc;
        xfers++;
        last_xd = bus.tx_data;
      end
      if (bus.in_data_taken) idt_seen = 1'b1;
      if (bus.abort) begin
        ab_seen = 1'b1;
        chk("tmo busy at abort", bus.busy, 0);
        break;
      end
      tick();
    end
    chk("tmo abort seen", ab_seen, 1);
    chk("tmo data0 sends", xfers, MAXR + 1);
    chk("tmo resend payload", last_xd, ID3);
    chk("tmo in_data_taken", idt_seen, 0);
    chk("tmo resend gap in range",
        ((second_x - first_x) >= TMO) && ((second_x - first_x) <= TMO + 3), 1);
    tick();
    chk("tmo abort pulse width", bus.abort, 0);
    chk("tmo tx_valid idle", bus.tx_valid, 0);

    // OUT with persistently corrupted DATA0: MAXR NAKs then abort with no NAK
    drive(1'b1, OUT, 7'd5, 4'd8, 64'h0, 1'b0, 1'b1, 1'b0, 64'h0);
    tick();
    naks = 0;
    for (int k = 0; k < MAXR; k++) begin
      drive(1'b1, D0, 7'd5, 4'd0, BAD, 1'b1, 1'b1, 1'b0, 64'h0);
      tick();
      quiet();
      if (bus.tx_valid && bus.tx_pid == NAK) naks++;
      tick();
    end
    chk("nak count", naks, MAXR);
    drive(1'b1, D0, 7'd5, 4'd0, BAD, 1'b1, 1'b1, 1'b0, 64'h0);
    tick();
    quiet();
    chk("nak-limit abort", bus.abort, 1);
    chk("nak-limit no handshake", bus.tx_valid, 0);
    chk("nak-limit busy", bus.busy, 0);
    chk("nak-limit no out_data_valid", bus.out_data_valid, 0);
    tick();
    chk("nak-limit abort pulse width", bus.abort, 0);

    // Reset asserted mid-cycle while waiting for ACK
    drive(1'b1, IN, 7'd5, 4'd9, 64'h0, 1'b0, 1'b1, 1'b1, ID3);
    tick();
    quiet();
    chk("pre-rst data0", bus.tx_valid, 1);
    tick();
    chk("pre-rst in W_ACK busy", bus.busy, 1);
    #3 rst_L = 1'b0;
    #1;
    chk("async rst busy", bus.busy, 0);
    chk("async rst out_endp", bus.out_endp, 0);
    chk("async rst tx", {bus.tx_valid, bus.tx_pid, bus.tx_data}, 0);
    chk("async rst pulses", {bus.out_data_valid, bus.in_data_taken, bus.abort}, 0);
    tick();
    rst_L = 1'b1;
    tick();
    drive(1'b1, IN, 7'd5, 4'd10, 64'h0, 1'b0, 1'b1, 1'b1, ID5);
    tick();
    quiet();
    chk("post-rst data0 pid", bus.tx_pid, D0);
    chk("post-rst data0 data", bus.tx_data, ID5);
    chk("post-rst out_endp", bus.out_endp, 10);
    tick();
    drive(1'b1, ACK, 7'd5, 4'd0, 64'h0, 1'b0, 1'b1, 1'b0, 64'h0);
    tick();
    quiet();
    chk("post-rst in_data_taken", bus.in_data_taken, 1);
    chk("post-rst busy", bus.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/usb_dev_protocol_fsm.md
Name: usb_dev_protocol_fsm

Overview:
- Device-side (responder) USB protocol engine. It answers the host-side OUT/IN transaction FSMs.
- Consumes decoded packets from the receive decoder and issues handshake/data packets to the transmit encoder.
- Delivers received OUT payloads upstream to the device endpoint logic, and sources IN payloads from it.
- Handles NAK/retry and timeout exactly as the host side expects.

Parameters:
- TIMEOUT_CYCLES, 20, idle cycles waiting for a host packet before counting a timeout.
- MAX_RETRIES, 8, NAK/timeout retries allowed per transaction before abort.

Ports:
- clk  input  1  clock
- rst_L  input  1  asynchronous active-low reset
- my_addr  input  7  device address to match against tokens
- pkt_valid  input  1  one-cycle pulse: decoded packet present on pkt_* fields
- pkt_pid  input  4  packet PID (OUT=0001, IN=1001, DATA0=0011, ACK=0010, NAK=1010)
- pkt_addr  input  7  token address field
- pkt_endp  input  4  token endpoint field
- pkt_data  input  64  DATA0 payload
- pkt_corrupted  input  1  CRC or format error on this packet
- tx_ready  input  1  encoder can accept a packet
- tx_valid  output  1  packet request to encoder
- tx_pid  output  4  PID to send
- tx_data  output  64  payload; 0 for handshakes
- in_data_valid  input  1  endpoint has IN payload available
- in_data  input  64  IN payload
- in_data_taken  output  1  pulse: IN payload ACKed by host
- out_data_valid  output  1  pulse: OUT payload accepted
- out_data  output  64  OUT payload
- out_endp  output  4  endpoint of the current transaction
- busy  output  1  high in any state other than IDLE
- abort  output  1  pulse: transaction abandoned

Behaviour:
- All outputs and state are registered. Reset values: state IDLE; all outputs 0; timer and retry counters 0.
- Assertion of rst_L low at any time, including mid-transaction, forces reset values immediately. No pulse is emitted.
- tx handshake: tx_valid, tx_pid and tx_data are held stable until the cycle in which tx_valid && tx_ready. The packet transfers in that cycle.
- Packets with pkt_corrupted are never treated as tokens or handshakes.
- Packets with pkt_addr != my_addr are ignored.
- Ignored packets do not touch the timer.
- States: IDLE, W_DATA, S_DATA, W_ACK, S_HS.
- IDLE, valid OUT token: latch out_endp; clear timer and retry counters; next state W_DATA.
- IDLE, valid IN token with in_data_valid=1: latch out_endp and in_data into the payload register; clear counters; next state S_DATA.
- IDLE, valid IN token with in_data_valid=0: send NAK via S_HS, return to IDLE.
- IDLE, any other packet: ignored.
- tx_valid asserts the cycle after the token pulse.
- W_DATA, DATA0 not corrupted: send ACK via S_HS, return to IDLE.
  - out_data and out_data_valid pulse (one cycle) in the same cycle tx_valid first rises with ACK.
- W_DATA, DATA0 corrupted: if retry < MAX_RETRIES, retry++, send NAK via S_HS, return to W_DATA with timer cleared. Otherwise pulse abort and go to IDLE with no NAK.
- W_DATA, other PIDs: ignored.
- W_DATA, no packet: timer increments each cycle. At timer == TIMEOUT_CYCLES, apply the retry rule (retry++, clear timer, stay in W_DATA) or pulse abort and go to IDLE.
- S_DATA: drive DATA0 with the latched payload. On transfer, clear timer and go to W_ACK.
- W_ACK, valid ACK: in_data_taken pulses one cycle; go to IDLE.
- W_ACK, NAK, corrupted packet, or timer == TIMEOUT_CYCLES: if retry < MAX_RETRIES, retry++ and resend via S_DATA. Otherwise pulse abort and go to IDLE; the payload is not taken.
- S_HS: hold the handshake packet until transfer, then enter the recorded return state.
- While waiting for tx_ready (S_DATA, S_HS): incoming pkt_valid is ignored and the timer is frozen.
- Counters saturate and never wrap. retry is 4 bits and the timer is 20 bits, as in the host FSMs.
- Simultaneous pkt_valid and timer == TIMEOUT_CYCLES: the packet wins.

Optional Feature:
- Macro: USB_DEV_STALL_EN.
- Defined: adds input port stall_endp[15:0]. A valid OUT or IN token whose pkt_endp bit is set is answered with STALL (PID 1110) via S_HS. The FSM then returns to IDLE; no data is exchanged and no counters change.
- Undefined: the port is absent and STALL is never sent.

Test Plan:
- my_addr=5. OUT token addr 5 endp 2, then DATA0 0xDEADBEEF_0123_4567 clean → ACK sent; out_data_valid pulses one cycle with that data; out_endp=2; FSM returns to IDLE.
- OUT token, DATA0 with corrupted=1 twice, then clean → two NAKs, then one ACK; out_data_valid pulses exactly once.
- IN token with in_data_valid=1, in_data=0x1122334455667788, tx_ready held low 3 cycles → DATA0 held stable on tx_*; after transfer an ACK causes in_data_taken to pulse once.
- IN token, host silent → DATA0 resent every TIMEOUT_CYCLES; after 8 retries abort pulses; in_data_taken stays 0; FSM in IDLE.
- IN token with in_data_valid=0 → single NAK and a return to IDLE. A token to addr 6 → no tx_valid at all.
- rst_L asserted in W_ACK → all outputs 0 immediately. The next IN token is handled normally.
